// File: rtl/trigger_delay_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | trigger_delay_pkg                                                      |
// | Shared defaults, channel mode encoding and slicing helpers.            |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package trigger_delay_pkg;

  localparam int CHANNELS_DEF = 4;
  localparam int WIDTH_DEF    = 16;
  localparam int QDEPTH_DEF   = 8;

  // Delay 0 is a combinational bypass and delay 1 is served by the output
  // register directly, because a push cannot also be popped in its own cycle.
  typedef enum logic [1:0] {
    MODE_BYPASS = 2'd0,
    MODE_DIRECT = 2'd1,
    MODE_QUEUE  = 2'd2
  } chan_mode_e;

  function automatic int occ_width(input int qdepth);
    return $clog2(qdepth) + 1;
  endfunction

  function automatic int slice_lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/trigger_delay_chan.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | trigger_delay_chan                                                     |
// | One trigger channel: edge detect, delay latch, timestamp queue.        |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module trigger_delay_chan
  import trigger_delay_pkg::*;
#(
  parameter  int WIDTH  = WIDTH_DEF,
  parameter  int QDEPTH = QDEPTH_DEF,
  localparam int PW     = occ_width(QDEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] now_i,
  input  logic [WIDTH-1:0] delay_i,
  input  logic             d_i,
  input  logic             flush_i,
  output logic             q_o,
  output logic [PW-1:0]    pending_o,
  output logic             overflow_o
);

  localparam int          AW       = $clog2(QDEPTH);
  localparam logic [PW-1:0] FULL_CNT = PW'(QDEPTH);

  logic             prev_q;
  logic [WIDTH-1:0] dly_act_q;
  logic [WIDTH-1:0] tgt_q [QDEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             ovf_q, ovf_d;

  logic             empty, full;
  logic [WIDTH-1:0] dly_eff;
  chan_mode_e       mode;
  logic             trig_edge, pop, push, drop, direct;

  // The delay follows the input only while nothing is queued, so queued
  // targets stay in firing order.
  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == FULL_CNT);
    dly_eff = empty ? delay_i : dly_act_q;
    if (dly_eff == '0) begin
      mode = MODE_BYPASS;
    end else if (dly_eff == WIDTH'(1)) begin
      mode = MODE_DIRECT;
    end else begin
      mode = MODE_QUEUE;
    end
  end

  always_comb begin
    trig_edge = rst_n & d_i & ~prev_q;
    pop       = ~empty & (tgt_q[rd_ptr_q] == (now_i + WIDTH'(1)));
    push      = trig_edge & ~flush_i & (mode == MODE_QUEUE) & (~full | pop);
    drop      = trig_edge & ~flush_i & (mode == MODE_QUEUE) & full & ~pop;
    direct    = trig_edge & ~flush_i & (mode == MODE_DIRECT);
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    q_d      = 1'b0;
    ovf_d    = ovf_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      q_d = pop | direct;
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      cnt_d = cnt_q + PW'(push) - PW'(pop);
      if (drop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_q    <= 1'b1;
      dly_act_q <= delay_i;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      cnt_q     <= '0;
      q_q       <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      prev_q    <= d_i;
      dly_act_q <= dly_eff;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      q_q       <= q_d;
      ovf_q     <= ovf_d;
    end
  end

  // Slot contents need no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      tgt_q[wr_ptr_q] <= now_i + dly_eff;
    end
  end

  assign q_o        = (trig_edge & (mode == MODE_BYPASS)) | q_q;
  assign pending_o  = cnt_q;
  assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/trigger_delay_mc.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | trigger_delay_mc                                                       |
// | Multi-channel trigger delay with a shared free-running timestamp.      |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module trigger_delay_mc
  import trigger_delay_pkg::*;
#(
  parameter  int CHANNELS = CHANNELS_DEF,
  parameter  int WIDTH    = WIDTH_DEF,
  parameter  int QDEPTH   = QDEPTH_DEF,
  localparam int PW       = occ_width(QDEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] delay,
  input  logic [CHANNELS-1:0]       d,
  input  logic                      flush,
  output logic [CHANNELS-1:0]       q,
  output logic [CHANNELS*PW-1:0]    pending,
  output logic [CHANNELS-1:0]       overflow
);

  logic [WIDTH-1:0] now_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      now_q <= '0;
    end else begin
      now_q <= now_q + WIDTH'(1);
    end
  end

  generate
    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      trigger_delay_chan #(
        .WIDTH  (WIDTH),
        .QDEPTH (QDEPTH)
      ) u_chan (
        .clk        (clk),
        .rst_n      (rst_n),
        .now_i      (now_q),
        .delay_i    (delay[slice_lo(i, WIDTH) +: WIDTH]),
        .d_i        (d[i]),
        .flush_i    (flush),
        .q_o        (q[i]),
        .pending_o  (pending[slice_lo(i, PW) +: PW]),
        .overflow_o (overflow[i])
      );
    end
  endgenerate

endmodule
`default_nettype wire

// File: doc/trigger_delay_mc.md
# trigger_delay_mc

Multi-channel, reset-safe trigger delay: each of CHANNELS trigger inputs is rising-edge detected and re-emitted as a single-cycle pulse exactly a programmable number of clock cycles later. Pending triggers are held as timestamps in a small per-channel queue, not in a bit-per-cycle RAM, so reset and flush reliably discard them. It sits between trigger sources (discriminators, external trigger inputs) and the acquisition/readout logic.

## Interface
- CHANNELS, 4, number of independent trigger channels
- WIDTH, 16, delay/timestamp width; max delay 2^WIDTH-1 cycles
- QDEPTH, 8, pending-trigger slots per channel; power of two, >= 2
- clk  in  1  system clock; one clock domain only
- rst_n  in  1  synchronous, active-low reset
- delay  in  CHANNELS*WIDTH  per-channel delay in cycles; channel i at [i*WIDTH +: WIDTH]
- d  in  CHANNELS  trigger inputs, synchronous to clk, level
- flush  in  1  discard all pending triggers in all channels
- q  out  CHANNELS  delayed single-cycle trigger pulses
- pending  out  CHANNELS*($clog2(QDEPTH)+1)  per-channel queue occupancy
- overflow  out  CHANNELS  sticky: a trigger was dropped on a full queue

## Operation
- Shared free-running WIDTH-bit counter `now`, increments every cycle, wraps.
- Edge: channel fires at cycle t when d[i]=1 at t and d[i]=0 at t-1; prior-sample register resets to 1 (no spurious edge out of reset while d is high).
- Active delay per channel (dly_act) latched from delay only when that channel's queue is empty (and every cycle while empty); a changed delay while triggers are pending takes effect once the queue drains. This keeps queued targets monotonic.
- dly_act = 0: bypass, q[i] = edge combinationally at cycle t; queue unused.
- dly_act >= 1: push target = now + dly_act (mod 2^WIDTH) at cycle t; q[i] asserted for one cycle at t+dly_act.
- Pop: when queue non-empty and head target == `now`+1, register q[i]=1 next cycle and pop. Equality compare is exact because all targets lie < 2^WIDTH cycles ahead.
- Full: edge with queue full and no pop that cycle → dropped, overflow[i] set. Push and pop in same cycle when full → push accepted.
- overflow cleared only by rst_n or flush.
- flush: same cycle, all queues emptied, pending → 0, registered q cleared next cycle, overflow cleared; an edge in the flush cycle is discarded. Bypass-mode q unaffected.

## Timing
- Reset (rst_n=0 at clock edge): q=0, pending=0, overflow=0, now=0, queues empty, dly_act reloaded from delay.
- Latency: exactly dly_act cycles from the sampling edge; 0 = combinational.
- Pulse width: always 1 cycle per rising edge; back-to-back edges (d toggling 1,0,1) produce pulses 2 cycles apart.
- Reset or flush mid-operation: no pulse from a trigger accepted before it, ever.
- pending updates the cycle after push/pop; overflow the cycle after the drop.
- Counter wrap: targets spanning now=2^WIDTH-1→0 fire on time.

## Structure
- Package trigger_delay_pkg: WIDTH/QDEPTH defaults, occupancy-width function, channel-slice helper.
- Sub-module trigger_delay_chan: one channel (edge detect, dly_act latch, circular queue of QDEPTH timestamps, head compare, overflow); top instantiates CHANNELS copies via generate and owns `now`.
- Queue in flops (QDEPTH small); no RAM.

## Test plan
- delay=5, single rising edge on d[0] at cycle 100 → q[0] high only at cycle 105; other channels silent.
- delay=0 on ch1, edge at cycle 50 → q[1] high at cycle 50, combinational.
- QDEPTH=8, delay=1000, 9 edges 2 cycles apart → 8 pulses at t+1000, 9th dropped, overflow[0]=1 and held; pending peaks at 8.
- delay=300, edge at now=65400 (WIDTH=16) → pulse at now=164 after wrap.
- delay=50, 3 edges queued, flush at cycle +20 → no q pulses, pending=0, overflow=0; a new edge after flush fires at +50.
- delay changed 100→10 while 2 triggers pending → both fire at +100; next edge after drain fires at +10; rst_n pulse mid-queue suppresses all pending pulses.
